// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Contents: fetch FSM state enum, bus widths, the NOP presented during bubbles.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);
  localparam logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(4);

  // IDLE: one cycle after reset, no request
  // REQ: request at pc outstanding
  // SQUASH: draining a request whose data will be dropped
  // HAVE: instruction buffered and presented
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2,
    HAVE   = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits of an address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus.
// Ports:
//   imem_req   fetch stage -> memory, request active
//   imem_addr  fetch stage -> memory, word-aligned address
//   imem_ack   memory -> fetch stage, one-cycle completion pulse
//   imem_rdata memory -> fetch stage, word returned with ack
interface if_fetch_stage_if;
  import if_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory bus with
// arbitrary latency, applies EXE branch redirects and hazard freezes, and presents
// {PC+4, Instruction, fetch_valid} to the IF/ID register.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   freeze            hazard stall, honoured only while an instruction is presented
//   branch_taken      redirect request (highest priority after reset)
//   branch_addr       redirect target, low two bits ignored
//   imem              instruction-memory bus (master side)
//   PC                pc+4 of the presented instruction
//   Instruction       presented word, NOP when fetch_valid is low
//   fetch_valid       PC/Instruction are meaningful this cycle
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  if_fetch_stage_if.master    imem,
  output logic [ADDR_W-1:0]   PC,
  output logic [INSTR_W-1:0]  Instruction,
  output logic                fetch_valid
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  squash_addr_q, squash_addr_d;
  logic [INSTR_W-1:0] inst_buf_q, inst_buf_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  branch_target;
  logic               req_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               valid_c;

  assign pc_inc        = pc_q + PC_STEP;
  assign branch_target = word_align(branch_addr);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      squash_addr_q <= ADDR_W'(0);
      inst_buf_q    <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_addr_q <= squash_addr_d;
      inst_buf_q    <= inst_buf_d;
    end
  end

  // Next-state, datapath updates and bus outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_addr_d = squash_addr_q;
    inst_buf_d    = inst_buf_q;
    req_c         = 1'b0;
    addr_c        = ADDR_W'(0);
    valid_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken) pc_d = branch_target;
      end

      REQ: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (imem.imem_ack) begin
          if (branch_taken) begin
            // Returned word belongs to the old path; refetch at the target.
            pc_d = branch_target;
          end else begin
            inst_buf_d = imem.imem_rdata;
            state_d    = HAVE;
          end
        end else if (branch_taken) begin
          // Request cannot be abandoned: remember its address and drain it.
          squash_addr_d = pc_q;
          pc_d          = branch_target;
          state_d       = SQUASH;
        end
      end

      SQUASH: begin
        req_c  = 1'b1;
        addr_c = squash_addr_q;
        if (branch_taken) pc_d = branch_target;
        if (imem.imem_ack) state_d = REQ;
      end

      HAVE: begin
        valid_c = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = REQ;
        end else if (!freeze) begin
          // Prefetch the next sequential word while the current one is consumed.
          req_c  = 1'b1;
          addr_c = pc_inc;
          pc_d   = pc_inc;
          if (imem.imem_ack) begin
            inst_buf_d = imem.imem_rdata;
          end else begin
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = addr_c;
  assign fetch_valid    = valid_c;
  assign Instruction    = valid_c ? inst_buf_q : NOP_INSTR;
  assign PC             = pc_inc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed segments plus randomized
// branch/freeze/latency traffic, compared against a transaction-level model.
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        fetch_valid;

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus),
    .PC           (PC),
    .Instruction  (Instruction),
    .fetch_valid  (fetch_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors;
  int checks;

  // Reference model: fetch progress expressed as transactions.
  bit          m_started;   // first post-reset cycle has elapsed
  bit          m_valid;     // an instruction is being presented
  bit          m_out;       // a memory request is in flight
  bit          m_discard;   // the in-flight result is on a dead path
  logic [31:0] m_pc;        // address of presented / next instruction
  logic [31:0] m_inst;
  logic [31:0] m_out_addr;

  // Memory model state.
  bit          mem_busy;
  int          mem_lat;
  int          lat_mode;    // 0: zero-wait, 1: random 0..3, 2: fixed 3

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started  = 1'b0;
    m_valid    = 1'b0;
    m_out      = 1'b0;
    m_discard  = 1'b0;
    m_pc       = 32'h0000_0000;
    m_inst     = 32'h0;
    m_out_addr = 32'h0;
    mem_busy   = 1'b0;
    mem_lat    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check({tag, "_addr"},  bus.imem_addr,     32'h0);
    check({tag, "_valid"}, 32'(fetch_valid),  32'd0);
    check({tag, "_instr"}, Instruction,       32'h0);
    check({tag, "_pc"},    PC,                32'h0000_0004);
  endtask

  task automatic model_step(input bit br, input bit fz, input bit ack,
                            input logic [31:0] rd, input logic [31:0] tgt);
    if (!m_started) begin
      m_started = 1'b1;
      if (br) m_pc = tgt;
      m_out      = 1'b1;
      m_discard  = 1'b0;
      m_out_addr = m_pc;
    end else if (m_out) begin
      if (ack) begin
        if (m_discard || br) begin
          if (br) m_pc = tgt;
          m_discard  = 1'b0;
          m_out_addr = m_pc;
        end else begin
          m_out   = 1'b0;
          m_valid = 1'b1;
          m_inst  = rd;
        end
      end else if (br) begin
        m_pc      = tgt;
        m_discard = 1'b1;
      end
    end else if (m_valid) begin
      if (br) begin
        m_valid    = 1'b0;
        m_pc       = tgt;
        m_out      = 1'b1;
        m_discard  = 1'b0;
        m_out_addr = m_pc;
      end else if (!fz) begin
        m_pc = m_pc + 32'd4;
        if (ack) begin
          m_inst = rd;
        end else begin
          m_valid    = 1'b0;
          m_out      = 1'b1;
          m_out_addr = m_pc;
        end
      end
    end
  endtask

  // mode 0: random branch/freeze; 1: quiet; 2: forced branch to fba; 3: freeze only
  task automatic cycle(input int mode, input logic [31:0] fba, input bit stray);
    bit          br;
    bit          fz;
    bit          ack;
    bit          exp_req;
    logic [31:0] ba;
    logic [31:0] rd;
    logic [31:0] exp_addr;

    @(negedge clk);
    br = 1'b0;
    fz = 1'b0;
    ba = $urandom;
    if (mode == 0) begin
      br = ($urandom_range(0, 9) == 0);
      fz = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0: ba = 32'h0000_0103;
        1: ba = 32'hFFFF_FFFC;
        2: ba = 32'hFFFF_FFF8;
        default: ba = $urandom;
      endcase
    end else if (mode == 2) begin
      br = 1'b1;
      ba = fba;
    end else if (mode == 3) begin
      fz = 1'b1;
    end
    branch_taken   = br;
    branch_addr    = ba;
    freeze         = fz;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    #1;

    if (!m_started) begin
      exp_req = 1'b0; exp_addr = 32'h0;
    end else if (m_out) begin
      exp_req = 1'b1; exp_addr = m_out_addr;
    end else if (br || fz) begin
      exp_req = 1'b0; exp_addr = 32'h0;
    end else begin
      exp_req = 1'b1; exp_addr = m_pc + 32'd4;
    end
    check("imem_req",  32'(bus.imem_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr,     exp_addr);

    ack = 1'b0;
    rd  = 32'h0;
    if (stray) begin
      ack = 1'b1;
      rd  = $urandom;
    end else if (bus.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        case (lat_mode)
          0: mem_lat = 0;
          1: mem_lat = int'($urandom_range(0, 3));
          default: mem_lat = 3;
        endcase
      end
      if (mem_lat == 0) begin
        ack = 1'b1;
        rd  = mem_data(bus.imem_addr);
      end
    end
    bus.imem_ack   = ack;
    bus.imem_rdata = rd;
    #1;

    check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
    check("instruction", Instruction,      m_valid ? m_inst : 32'h0);
    check("pc_out",      PC,               m_pc + 32'd4);

    @(posedge clk);
    model_step(br, fz, ack, rd, ba & ~32'h3);
    if (ack) mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
  endtask

  initial begin
    bit found;
    errors         = 0;
    checks         = 0;
    rst            = 1'b0;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_addr    = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    lat_mode       = 0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    // Zero-wait streaming from reset.
    repeat (6) cycle(1, 32'h0, 1'b0);
    // Freeze while presenting, then resume.
    repeat (2) cycle(3, 32'h0, 1'b0);
    repeat (2) cycle(1, 32'h0, 1'b0);
    // Redirect to the top of memory and wrap through zero.
    cycle(2, 32'hFFFF_FFFC, 1'b0);
    repeat (4) cycle(1, 32'h0, 1'b0);
    // Wait-state memory, then a redirect landing on an outstanding request.
    lat_mode = 2;
    repeat (8) cycle(1, 32'h0, 1'b0);
    cycle(2, 32'h0000_0103, 1'b0);
    repeat (10) cycle(1, 32'h0, 1'b0);

    // Randomized traffic across latency regimes.
    lat_mode = 1;
    repeat (150) cycle(0, 32'h0, 1'b0);
    lat_mode = 0;
    repeat (150) cycle(0, 32'h0, 1'b0);
    lat_mode = 1;
    repeat (150) cycle(0, 32'h0, 1'b0);

    // Asynchronous reset while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_started && m_out) found = 1'b1;
      else cycle(0, 32'h0, 1'b0);
    end
    check("find_outstanding", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    // Stray ack in the first post-reset cycle must be ignored.
    cycle(1, 32'h0, 1'b1);
    lat_mode = 0;
    repeat (10) cycle(1, 32'h0, 1'b0);
    lat_mode = 1;
    repeat (100) cycle(0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
